// File: rtl/mem_stage_if.sv
// Data-memory port of the Pillar memory-access stage.
// The stage is the master (issues requests); the memory is the slave.
interface mem_stage_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the Pillar pipeline. Takes one instruction from
// execute, runs a req/ack data-memory transaction for loads and stores,
// passes ALU results straight through and hands a 32-bit write-back value
// to the write stage with a one-cycle strobe. Misalignment, illegal load/
// store widths and memory timeouts park the stage in a sticky error state.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        alu_i,
  input  logic [31:0]        rs2_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        ir_i,
  mem_stage_if.master        mem,
  output logic [31:0]        wd_o,
  output logic               wd_q_readin_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        ir_o,
  output logic               err_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_rs2;
  logic [31:0]      r_pc;
  logic [31:0]      r_ir;
  logic [31:0]      r_wd;

  // Load extraction: pick the addressed lane and sign/zero extend.
  function automatic logic [31:0] f_load_ext(input logic [2:0]  f3,
                                             input logic [1:0]  a,
                                             input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  f_load_ext = {{24{b[7]}}, b};
      3'b001:  f_load_ext = {{16{h[15]}}, h};
      3'b010:  f_load_ext = d;
      3'b100:  f_load_ext = {24'd0, b};
      3'b101:  f_load_ext = {16'd0, h};
      default: f_load_ext = 32'd0;
    endcase
  endfunction

  // Byte enables for the access width at the given lane.
  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   f_be = 4'b0001 << a;
      2'b01:   f_be = 4'b0011 << {a[1], 1'b0};
      default: f_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the byte enables select it.
  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   f_wdata = {4{d[7:0]}};
      2'b01:   f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  // Decode of the instruction being offered by execute.
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic       w_is_alu;
  logic       w_is_ld;
  logic       w_is_st;
  logic       w_bad_f3;
  logic       w_misal;

  assign w_opc    = ir_i[6:0];
  assign w_f3     = ir_i[14:12];
  assign w_is_alu = (w_opc == OP_R) || (w_opc == OP_I);
  assign w_is_ld  = (w_opc == OP_LOAD);
  assign w_is_st  = (w_opc == OP_STORE);
  // Loads allow 000/001/010/100/101; stores allow 000/001/010.
  assign w_bad_f3 = w_is_ld ? (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111)
                            : (w_f3 > 3'b010);
  assign w_misal  = ((w_f3[1:0] == 2'b01) && alu_i[0]) ||
                    ((w_f3[1:0] == 2'b10) && (alu_i[1:0] != 2'b00));

  // Control FSM with captured instruction, timeout counter and write-back value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rs2   <= '0;
      r_pc    <= '0;
      r_ir    <= '0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_addr <= alu_i;
            r_rs2  <= rs2_i;
            r_pc   <= pc_i;
            r_ir   <= ir_i;
            r_cnt  <= '0;
            if (w_is_ld || w_is_st) begin
              r_state <= (w_bad_f3 || w_misal) ? S_ERR : S_MEM;
            end else begin
              r_wd    <= w_is_alu ? alu_i : 32'd0;
              r_state <= S_DONE;
            end
          end
        end
        S_MEM: begin
          if (mem.mem_ack_i) begin
            r_wd    <= (r_ir[6:0] == OP_LOAD)
                       ? f_load_ext(r_ir[14:12], r_addr[1:0], mem.mem_rdata_i)
                       : 32'd0;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register, so reset clears them at once.
  logic w_req;
  logic w_st;
  assign w_req = (r_state == S_MEM);
  assign w_st  = (r_ir[6:0] == OP_STORE);

  assign in_ready_o      = (r_state == S_IDLE);
  assign wd_q_readin_o   = (r_state == S_DONE);
  assign err_o           = (r_state == S_ERR);
  assign wd_o            = r_wd;
  assign pc_o            = r_pc;
  assign ir_o            = r_ir;

  assign mem.mem_req_o   = w_req;
  assign mem.mem_we_o    = w_req && w_st;
  assign mem.mem_addr_o  = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem.mem_be_o    = w_req ? f_be(r_ir[14:12], r_addr[1:0]) : 4'd0;
  assign mem.mem_wdata_o = (w_req && w_st) ? f_wdata(r_ir[14:12], r_rs2) : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, loads, stores,
// misalignment error and memory timeout.
module tb_mem_stage;
  logic        clk;
  logic        reset;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] alu_i, rs2_i, pc_i, ir_i;
  logic [31:0] wd_o, pc_o, ir_o;
  logic        wd_q_readin_o;
  logic        err_o;

  int n_total;
  int n_fail;

  mem_stage_if mem_if ();

  mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .alu_i         (alu_i),
    .rs2_i         (rs2_i),
    .pc_i          (pc_i),
    .ir_i          (ir_i),
    .mem           (mem_if),
    .wd_o          (wd_o),
    .wd_q_readin_o (wd_q_readin_o),
    .pc_o          (pc_o),
    .ir_o          (ir_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] ir, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [31:0] pc);
    in_valid_i = 1'b1;
    ir_i = ir; alu_i = alu; rs2_i = rs2; pc_i = pc;
    tick();
    in_valid_i = 1'b0;
  endtask

  initial begin
    int n_req;
    int n_stb;
    n_total = 0;
    n_fail  = 0;
    reset = 1'b1;
    in_valid_i = 1'b0;
    alu_i = '0; rs2_i = '0; pc_i = '0; ir_i = '0;
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = '0;
    tick();
    tick();

    // Reset state
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_req",   32'(mem_if.mem_req_o), 32'd0);
    chk("rst_strobe",32'(wd_q_readin_o), 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    chk("rst_wd",    wd_o, 32'd0);
    chk("rst_pc",    pc_o, 32'd0);
    reset = 1'b0;
    tick();

    // Reset while a load is waiting for ack
    offer(32'h0000_2003, 32'h0000_0100, 32'd0, 32'h4);
    chk("mid_req_on", 32'(mem_if.mem_req_o), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_req_drop", 32'(mem_if.mem_req_o), 32'd0);
    chk("mid_ready",    32'(in_ready_o), 32'd1);
    tick();
    reset = 1'b0;
    n_stb = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wd_q_readin_o) n_stb++;
    end
    chk("mid_no_strobe", 32'(n_stb), 32'd0);

    // R-type pass-through
    offer(32'h0000_0033, 32'h0000_0005, 32'd0, 32'h10);
    chk("r_strobe", 32'(wd_q_readin_o), 32'd1);
    chk("r_wd",     wd_o, 32'h5);
    chk("r_pc",     pc_o, 32'h10);
    chk("r_ir",     ir_o, 32'h33);
    chk("r_busy",   32'(in_ready_o), 32'd0);
    tick();
    chk("r_strobe_off", 32'(wd_q_readin_o), 32'd0);
    chk("r_ready",      32'(in_ready_o), 32'd1);
    chk("r_wd_hold",    wd_o, 32'h5);

    // Unknown opcode passes through with zero
    offer(32'h0000_007F, 32'h0000_1234, 32'd0, 32'h14);
    chk("unk_strobe", 32'(wd_q_readin_o), 32'd1);
    chk("unk_wd",     wd_o, 32'd0);
    tick();

    // LB from lane 3, ack on first request cycle
    offer(32'h0000_0003, 32'h0000_0103, 32'd0, 32'h20);
    chk("lb_req",  32'(mem_if.mem_req_o), 32'd1);
    chk("lb_addr", mem_if.mem_addr_o, 32'h100);
    chk("lb_we",   32'(mem_if.mem_we_o), 32'd0);
    chk("lb_pc",   pc_o, 32'h20);
    chk("lb_no_strobe_yet", 32'(wd_q_readin_o), 32'd0);
    mem_if.mem_ack_i   = 1'b1;
    mem_if.mem_rdata_i = 32'h80FF_1234;
    tick();
    mem_if.mem_ack_i = 1'b0;
    chk("lb_strobe", 32'(wd_q_readin_o), 32'd1);
    chk("lb_wd",     wd_o, 32'hFFFF_FF80);
    chk("lb_req_off",32'(mem_if.mem_req_o), 32'd0);
    tick();

    // LBU, same address and data
    offer(32'h0000_4003, 32'h0000_0103, 32'd0, 32'h24);
    mem_if.mem_ack_i = 1'b1;
    tick();
    mem_if.mem_ack_i = 1'b0;
    chk("lbu_strobe", 32'(wd_q_readin_o), 32'd1);
    chk("lbu_wd",     wd_o, 32'h0000_0080);
    tick();

    // SH to upper half, ack after three waiting cycles
    offer(32'h0000_1023, 32'h0000_0202, 32'h0000_ABCD, 32'h28);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req",   32'(mem_if.mem_req_o), 32'd1);
      chk("sh_we",    32'(mem_if.mem_we_o), 32'd1);
      chk("sh_be",    32'(mem_if.mem_be_o), 32'hC);
      chk("sh_wdata", mem_if.mem_wdata_o, 32'hABCD_ABCD);
      chk("sh_addr",  mem_if.mem_addr_o, 32'h200);
      chk("sh_no_strobe", 32'(wd_q_readin_o), 32'd0);
      tick();
    end
    mem_if.mem_ack_i = 1'b1;
    tick();
    mem_if.mem_ack_i = 1'b0;
    chk("sh_strobe",  32'(wd_q_readin_o), 32'd1);
    chk("sh_wd",      wd_o, 32'd0);
    chk("sh_req_off", 32'(mem_if.mem_req_o), 32'd0);
    tick();

    // SB to lane 1
    offer(32'h0000_0023, 32'h0000_0301, 32'h0000_00A5, 32'h2C);
    chk("sb_be",    32'(mem_if.mem_be_o), 32'h2);
    chk("sb_wdata", mem_if.mem_wdata_o, 32'hA5A5_A5A5);
    mem_if.mem_ack_i = 1'b1;
    tick();
    mem_if.mem_ack_i = 1'b0;
    tick();

    // Misaligned LW goes straight to the error state
    offer(32'h0000_2003, 32'h0000_0101, 32'd0, 32'h30);
    chk("mis_err",   32'(err_o), 32'd1);
    chk("mis_req",   32'(mem_if.mem_req_o), 32'd0);
    chk("mis_ready", 32'(in_ready_o), 32'd0);
    in_valid_i = 1'b1;
    ir_i = 32'h0000_0033;
    n_stb = 0;
    n_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (in_ready_o) n_req++;
      if (wd_q_readin_o) n_stb++;
    end
    in_valid_i = 1'b0;
    chk("mis_ready_held", 32'(n_req), 32'd0);
    chk("mis_no_strobe",  32'(n_stb), 32'd0);
    chk("mis_err_held",   32'(err_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("mis_rst_err",   32'(err_o), 32'd0);
    chk("mis_rst_ready", 32'(in_ready_o), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    // Aligned LW with no ack: timeout after 16 request cycles
    offer(32'h0000_2003, 32'h0000_0100, 32'd0, 32'h34);
    n_req = 0;
    n_stb = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_if.mem_req_o) n_req++;
      if (wd_q_readin_o) n_stb++;
      tick();
    end
    chk("to_req_cycles", 32'(n_req), 32'd16);
    chk("to_no_strobe",  32'(n_stb), 32'd0);
    chk("to_err",        32'(err_o), 32'd1);
    chk("to_req_off",    32'(mem_if.mem_req_o), 32'd0);
    chk("to_ready",      32'(in_ready_o), 32'd0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the Pillar pipeline, directly upstream of the write-back stage.
- Accepts one instruction at a time from execute: ALU result, rs2 data, pc, ir.
- Loads and stores perform a req/ack transaction on the data-memory port. R-type and I-type ALU results pass straight through.
- Output is a 32-bit write-back value plus a one-cycle strobe (wd_q_readin_o). The write stage latches the value on the strobe's rising edge. pc_o and ir_o are forwarded alongside.

Parameters:
- TIMEOUT, 16, max cycles mem_req_o may be held without mem_ack_i before the error state (>=1).
- CNT_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid_i  in  1  execute presents an instruction
- in_ready_o  out  1  stage can accept (IDLE only)
- alu_i  in  32  ALU result / effective address
- rs2_i  in  32  store data
- pc_i  in  32  instruction pc
- ir_i  in  32  instruction word
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = store
- mem_addr_o  out  32  word-aligned address (alu[31:2],2'b00)
- mem_wdata_o  out  32  store data, lane-shifted
- mem_be_o  out  4  byte enables
- mem_ack_i  in  1  memory completes request
- mem_rdata_i  in  32  load data, valid with ack
- wd_o  out  32  write-back value to write stage
- wd_q_readin_o  out  1  one-cycle strobe, wd_o valid
- pc_o  out  32  captured pc
- ir_o  out  32  captured ir
- err_o  out  1  sticky error (misaligned or timeout)

Behaviour:
- Reset: async assert forces IDLE.
  - All outputs 0 except in_ready_o=1.
  - Captured regs and counter cleared.
  - Reset mid-transaction drops mem_req_o immediately and no strobe is issued.
- Opcodes (ir[6:0]): R 0110011, I 0010011, LOAD 0000011, STORE 0100011. Any other opcode is treated as pass-through with wd=0.
- FSM states: IDLE, MEM, DONE, ERR.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i, capture alu/rs2/pc/ir; pc_o and ir_o update this edge.
  - R/I: wd_o<=alu_i, go DONE.
  - LOAD/STORE aligned: go MEM, drive mem_* from the next cycle.
  - Misaligned: go ERR. Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
- MEM:
  - mem_req_o=1; addr/we/wdata/be held stable until ack.
  - Counter increments each cycle without ack.
  - On mem_ack_i=1: mem_req_o deasserts next cycle, go DONE.
    - Load: wd_o<=extended data.
    - Store: wd_o<=0.
  - If counter reaches TIMEOUT with no ack: go ERR, mem_req_o drops.
  - Ack in the same cycle as the first req cycle is legal.
- DONE: wd_q_readin_o=1 for exactly this cycle, in_ready_o=0, then IDLE.
- ERR:
  - err_o=1, in_ready_o=0, mem_req_o=0, no strobe.
  - Held until reset.
- Load extraction (funct3=ir[14:12]); byte lane = addr[1:0], halfword lane = addr[1]:
  - LB 000: sign-extend byte.
  - LH 001: sign-extend halfword.
  - LW 010: full word.
  - LBU 100: zero-extend byte.
  - LHU 101: zero-extend halfword.
  - Other funct3 values go to ERR.
- Stores:
  - SB: be=4'b0001<<addr[1:0], wdata=byte replicated x4.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata=halfword replicated x2.
  - SW: be=4'b1111, wdata=rs2.
  - Other funct3 values go to ERR.
- Latency (accept edge = N):
  - ALU op: strobe in cycle N+1.
  - Memory op with ack at k-th MEM cycle: strobe at N+1+k.
- in_valid_i outside IDLE is ignored and not captured. Upstream holds data until in_ready_o=1 is seen with valid.
- wd_o, pc_o, ir_o hold their last value after the strobe until the next capture.

Test Plan:
- Reset high mid-MEM, mem_ack_i never asserted -> mem_req_o=0 and in_ready_o=1 in the same cycle as reset; no strobe after release.
- R-type, alu_i=0x00000005, pc_i=0x10 -> wd_o=0x5, pc_o=0x10, strobe exactly one cycle, one cycle after accept.
- LB, alu_i=0x103, mem_rdata_i=0x80FF1234, ack on first req cycle:
  - mem_addr_o=0x100, mem_we_o=0.
  - wd_o=0xFFFFFF80, strobe two cycles after accept.
  - Repeat as LBU -> wd_o=0x00000080.
- SH, alu_i=0x202, rs2_i=0x0000ABCD, ack delayed 3 cycles:
  - mem_be_o=4'b1100, mem_wdata_o=0xABCDABCD, mem_we_o=1, all held stable 3 cycles.
  - wd_o=0, strobe after ack.
- LW, alu_i=0x101 -> ERR immediately: err_o=1, no mem_req_o, in_ready_o stays 0 through further in_valid_i.
- LW aligned, TIMEOUT=16, no ack -> mem_req_o high exactly 16 cycles, then err_o=1, mem_req_o=0, no strobe.
